imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
// - Decode-stage immediate generator, successor to the I/S/B-only extender.
// - Covers all RV32I formats (I/S/B/U/J), parametrised output width XLEN, registered output.
// - Carries a valid/ready handshake with a 2-entry skid buffer so execute-stage stalls do not cut timing to fetch.
// - Adds decode flush, an illegal-select flag and a saturating illegal-select counter.
// PARAMETERS
// - XLEN      32            output width; 32 or 64, sign-extended to XLEN
// - TAG_W     5             width of sideband tag carried with each immediate (e.g. rd)
// - CNT_W     8             width of illegal-select counter
// - ILL_FILL  32'hDEADBEEF  value driven on imm for an illegal select; zero-extended to XLEN
// PORTS
// - clk          in   1       rising-edge clock
// - rst_n        in   1       asynchronous, active-low reset
// - flush        in   1       drop all buffered entries (branch redirect)
// - in_valid     in   1       instr/imm_src/in_tag are valid
// - in_ready     out  1       block can accept this cycle
// - instr        in   32      raw instruction word
// - imm_src      in   3       000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal
// - in_tag       in   TAG_W   sideband, passed through unchanged
// - out_valid    out  1       imm/out_illegal/out_tag are valid
// - out_ready    in   1       consumer accepts this cycle
// - imm          out  XLEN    extended immediate
// - out_illegal  out  1       imm_src was illegal for this entry
// - out_tag      out  TAG_W   tag of this entry
// - ill_cnt      out  CNT_W   saturating count of accepted illegal selects
// BEHAVIOUR
// - Formats: I={instr[31:20]}; S={instr[31:25],instr[11:7]}; B={instr[31],instr[7],instr[30:25],instr[11:8],0};
//   U={instr[31:12],12'b0}; J={instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended from their MSB to XLEN.
// - Illegal select: imm=ILL_FILL, out_illegal=1; entry still flows through the pipe.
// - Accept on in_valid&in_ready; deliver on out_valid&out_ready. Latency 1 cycle, accept to out_valid.
// - Storage: output reg OUT + skid reg SKID. States: EMPTY(no valid), ONE(OUT valid), FULL(OUT+SKID valid).
//   EMPTY: accept->ONE.
//   ONE: accept&deliver->ONE (OUT reloaded); accept only->FULL (new to SKID); deliver only->EMPTY.
//   FULL: deliver->ONE (SKID moves to OUT); no accept possible.
// - in_ready = (state!=FULL); registered, no combinational path from out_ready.
// - Order strictly FIFO; out_* stable while out_valid&!out_ready.
// - flush: next state EMPTY regardless of handshakes that cycle; input presented that cycle is dropped and not counted.
//   A delivery in the flush cycle is still a valid transfer.
// - ill_cnt increments by 1 on each accepted illegal entry (not on flush cycle); saturates at all-ones; cleared only by reset.
// - Reset (async assert, sync deassert external): state EMPTY, out_valid=0, in_ready=1,
//   imm=0, out_illegal=0, out_tag=0, ill_cnt=0.
// - Reset mid-stream discards both entries with no partial output.
// STRUCTURE
// - Package imm_pkg: imm_src_e enum (IMM_I..IMM_J), state enum skid_state_e, default ILL_FILL constant.
// - Sub-module imm_decode: combinational format select + sign-extend (instr, imm_src -> imm, illegal).
// - Top holds the skid FSM, data regs and counter.
// TESTING
// - I: instr=32'hFFF00093, src=000 -> next cycle imm=32'hFFFFFFFF, out_illegal=0.
// - S/B: 32'hFE512E23 src=001 -> 32'hFFFFFFFC.
//   32'hFE000CE3 src=010 -> 32'hFFFFFFF8.
// - U/J: 32'h123450B7 src=011 -> 32'h12345000.
//   32'hFFDFF06F src=100 -> 32'hFFFFFFFC.
//   XLEN=64 J case -> 64'hFFFFFFFFFFFFFFFC.
// - Backpressure: out_ready=0, push tags 1,2 back-to-back -> in_ready=0 after 2nd;
//   release -> tags 1 then 2, nothing lost or duplicated.
// - Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed input never appears.
// - Illegal: src=111 -> imm=32'hDEADBEEF, out_illegal=1, ill_cnt+1.
//   CNT_W=2, 5 illegals -> ill_cnt=3. rst_n low mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and constants for the immediate generator
package imm_pkg;

    // Immediate format select; encodings 5..7 are illegal.
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    // Occupancy of the output register plus skid register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam logic [31:0] ILL_FILL_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV32I immediate format select and sign-extend
// Ports:
//   instr    in   32     raw instruction word
//   imm_src  in   3      format select (I/S/B/U/J, others illegal)
//   imm      out  XLEN   sign-extended immediate, or ILL_FILL zero-extended when illegal
//   illegal  out  1      imm_src is not a defined format
module imm_decode
    import imm_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] ILL_FILL = ILL_FILL_DEFAULT
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] raw;

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   raw = {instr[31:12], 12'b0};
            IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: illegal = 1'b1;
        endcase
        // raw already holds a 32-bit sign-extended value; widen it to XLEN.
        imm = illegal ? XLEN'(ILL_FILL) : XLEN'($signed(raw));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop all buffered entries and the current input
//   in_valid/in_ready   input handshake for instr, imm_src, in_tag
//   out_valid/out_ready output handshake for imm, out_illegal, out_tag
//   ill_cnt             saturating count of accepted illegal selects
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          TAG_W    = 5,
    parameter int          CNT_W    = 8,
    parameter logic [31:0] ILL_FILL = ILL_FILL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] ill_cnt
);

    skid_state_e state, state_nxt;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;
    logic [XLEN-1:0]  skid_imm;
    logic             skid_ill;
    logic [TAG_W-1:0] skid_tag;

    logic accept;
    logic deliver;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid;

    imm_decode #(
        .XLEN     (XLEN),
        .ILL_FILL (ILL_FILL)
    ) u_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    // Both handshake outputs decode the state register only, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);

    assign accept  = in_valid & in_ready & ~flush;
    assign deliver = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt   = ST_ONE;
                        load_out_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                        load_skid = 1'b1;
                    end else if (deliver) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        state_nxt     = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm         <= '0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (load_out_in) begin
            imm         <= dec_imm;
            out_illegal <= dec_ill;
            out_tag     <= in_tag;
        end else if (load_out_skid) begin
            imm         <= skid_imm;
            out_illegal <= skid_ill;
            out_tag     <= skid_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_imm <= '0;
            skid_ill <= 1'b0;
            skid_tag <= '0;
        end else if (load_skid) begin
            skid_imm <= dec_imm;
            skid_ill <= dec_ill;
            skid_tag <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (accept && dec_ill && (ill_cnt != {CNT_W{1'b1}})) begin
            ill_cnt <= ill_cnt + CNT_W'(1);
        end
    end

endmodule
